// File: rtl/ysyx_22050078_wbu_regfile_if.sv
// EXU -> WBU result handshake bundle.
// master = execute unit (drives result), slave = write-back unit (drives ready).
interface ysyx_22050078_wbu_regfile_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
);
  logic                  ex_valid;
  logic                  ex_ready;
  logic [ADDR_WIDTH-1:0] ex_rd_addr;
  logic [DATA_WIDTH-1:0] ex_rd_data;
  logic                  ex_rd_wen;

  modport master (
    output ex_valid,
    output ex_rd_addr,
    output ex_rd_data,
    output ex_rd_wen,
    input  ex_ready
  );

  modport slave (
    input  ex_valid,
    input  ex_rd_addr,
    input  ex_rd_data,
    input  ex_rd_wen,
    output ex_ready
  );
endinterface

// File: rtl/ysyx_22050078_wbu_regfile.sv
// Write-back stage with one-entry WB register, 32-entry integer register file,
// two bypassed read ports, a committed-only debug port and a retire counter.
// Ports: clk, rst (sync, active-high); ex (EXU result handshake, slave side);
// wb_stall; rs1/rs2 read ports; dbg read port; wb_valid; retire_cnt.
module ysyx_22050078_wbu_regfile #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  ysyx_22050078_wbu_regfile_if.slave ex,
  input  logic                  wb_stall,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0] rs2_data,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data,
  output logic                  wb_valid,
  output logic [63:0]           retire_cnt
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_rf [DEPTH];

  logic                  r_wb_valid;
  logic [ADDR_WIDTH-1:0] r_wb_addr;
  logic [DATA_WIDTH-1:0] r_wb_data;
  logic                  r_wb_wen;
  logic [63:0]           r_retire;

  logic w_accept;
  logic w_commit;
  logic w_write;
  logic w_fwd1;
  logic w_fwd2;

  // Ready whenever the slot is empty or is draining this cycle.
  assign ex.ex_ready = !r_wb_valid || !wb_stall;
  assign w_accept    = ex.ex_valid && ex.ex_ready;
  assign w_commit    = r_wb_valid && !wb_stall;
  assign w_write     = w_commit && r_wb_wen
                    && (r_wb_addr != '0);

  // WB entry register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_valid <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
      r_wb_wen   <= 1'b0;
    end else if (w_accept) begin
      r_wb_valid <= 1'b1;
      r_wb_addr  <= ex.ex_rd_addr;
      r_wb_data  <= ex.ex_rd_data;
      r_wb_wen   <= ex.ex_rd_wen;
    end else if (w_commit) begin
      r_wb_valid <= 1'b0;
    end
  end

  // Architectural register file; x0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_rf[i] <= '0;
      end
    end else if (w_write) begin
      r_rf[r_wb_addr] <= r_wb_data;
    end
  end

  // Retire counter counts every committed entry, wen or not.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retire <= '0;
    end else if (w_commit) begin
      r_retire <= r_retire + 64'd1;
    end
  end

  // Forward the pending entry, even while stalled.
  assign w_fwd1 = (BYPASS != 0) && r_wb_valid
               && r_wb_wen && (rs1_addr != '0)
               && (r_wb_addr == rs1_addr);
  assign w_fwd2 = (BYPASS != 0) && r_wb_valid
               && r_wb_wen && (rs2_addr != '0)
               && (r_wb_addr == rs2_addr);

  always_comb begin
    rs1_data = '0;
    if (rs1_addr == '0) begin
      rs1_data = '0;
    end else if (w_fwd1) begin
      rs1_data = r_wb_data;
    end else begin
      rs1_data = r_rf[rs1_addr];
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr == '0) begin
      rs2_data = '0;
    end else if (w_fwd2) begin
      rs2_data = r_wb_data;
    end else begin
      rs2_data = r_rf[rs2_addr];
    end
  end

  always_comb begin
    dbg_data = '0;
    if (dbg_addr != '0) begin
      dbg_data = r_rf[dbg_addr];
    end
  end

  assign wb_valid   = r_wb_valid;
  assign retire_cnt = r_retire;

endmodule
